mult_div_unit: RTL and testbench

- Multicycle integer multiply/divide unit that sits directly downstream of the ALU stage.
- It owns the architectural HI/LO registers and executes MULT, MULTU, DIV and DIVU iteratively, one bit per cycle. This replaces single-cycle combinational HI/LO generation.
- It accepts the same rs/rt operand contents the ALU receives and asserts busy so the control path stalls while an operation runs.
- It also services MTHI/MTLO writes. HI/LO are exported continuously for MFHI/MFLO.

---
 rtl/mult_div_unit.sv | 137 +++++++++++++
 tb/tb_mult_div_unit.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/mult_div_unit.sv
// Iterative multiply/divide unit owning the HI/LO registers.
// One result bit per cycle: latch, WIDTH iterations, then a sign/fixup cycle.
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] rs_content,
  input  logic [WIDTH-1:0] rt_content,
  input  logic             mthi,
  input  logic             mtlo,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic [1:0]         state;
  logic [CW-1:0]      iter;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   mag_b;
  logic [WIDTH-1:0]   rs_orig;
  logic               is_div;
  logic               div_zero;
  logic               neg_q;
  logic               neg_r;

  logic [WIDTH:0]       add_sum;
  logic [WIDTH:0]       shifted;
  logic [WIDTH:0]       diff;
  logic                 sub_ok;
  logic [2*WIDTH-1:0]   acc_next;
  logic [2*WIDTH-1:0]   prod_fix;
  logic [WIDTH-1:0]     quo_fix;
  logic [WIDTH-1:0]     rem_fix;

  // 0x80000000 maps to unsigned 2^31, which fits the unsigned core as-is.
  function automatic logic [WIDTH-1:0] abs_val(input logic [WIDTH-1:0] x,
                                               input logic             sgn);
    return (sgn && x[WIDTH-1]) ? (~x + 1'b1) : x;
  endfunction

  function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] x,
                                                input logic             n);
    return n ? (~x + 1'b1) : x;
  endfunction

  function automatic logic [2*WIDTH-1:0] cond_neg2(input logic [2*WIDTH-1:0] x,
                                                   input logic               n);
    return n ? (~x + 1'b1) : x;
  endfunction

  assign busy = (state != S_IDLE);

  // acc holds {partial product high, multiplier} or {remainder, dividend/quotient}
  always_comb begin
    add_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} +
               (acc[0] ? {1'b0, mag_b} : {(WIDTH+1){1'b0}});
    shifted  = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    sub_ok   = (shifted >= {1'b0, mag_b});
    diff     = shifted - {1'b0, mag_b};
    acc_next = {add_sum, acc[WIDTH-1:1]};
    if (is_div)
      acc_next = {(sub_ok ? diff[WIDTH-1:0] : shifted[WIDTH-1:0]),
                  acc[WIDTH-2:0], sub_ok};
  end

  // Divide by zero reports all-ones quotient and the untouched dividend.
  always_comb begin
    prod_fix = cond_neg2(acc, neg_q);
    quo_fix  = div_zero ? {WIDTH{1'b1}} : cond_neg(acc[WIDTH-1:0], neg_q);
    rem_fix  = div_zero ? rs_orig : cond_neg(acc[2*WIDTH-1:WIDTH], neg_r);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      iter     <= '0;
      acc      <= '0;
      mag_b    <= '0;
      rs_orig  <= '0;
      is_div   <= 1'b0;
      div_zero <= 1'b0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      done     <= 1'b0;
      hi       <= '0;
      lo       <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            state    <= S_RUN;
            iter     <= '0;
            acc      <= {{WIDTH{1'b0}}, abs_val(rs_content, ~op[0])};
            mag_b    <= abs_val(rt_content, ~op[0]);
            rs_orig  <= rs_content;
            is_div   <= op[1];
            div_zero <= (rt_content == '0);
            neg_q    <= ~op[0] & (rs_content[WIDTH-1] ^ rt_content[WIDTH-1]);
            neg_r    <= ~op[0] & rs_content[WIDTH-1];
          end else begin
            if (mthi) hi <= rs_content;
            if (mtlo) lo <= rs_content;
          end
        end
        S_RUN: begin
          acc  <= acc_next;
          iter <= iter + 1'b1;
          if (iter == CW'(WIDTH-1))
            state <= S_FIX;
        end
        S_FIX: begin
          if (is_div) begin
            hi <= rem_fix;
            lo <= quo_fix;
          end else begin
            hi <= prod_fix[2*WIDTH-1:WIDTH];
            lo <= prod_fix[WIDTH-1:0];
          end
          done  <= 1'b1;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit: stimulus queues expected HI/LO,
// a monitor pops and compares on every done pulse.
module tb_mult_div_unit;
  localparam int W = 32;
  localparam logic [1:0] MULT = 2'b00, MULTU = 2'b01, DIV = 2'b10, DIVU = 2'b11;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [1:0]   op = 2'b00;
  logic [W-1:0] rs_content = '0;
  logic [W-1:0] rt_content = '0;
  logic         mthi = 1'b0;
  logic         mtlo = 1'b0;
  logic         busy;
  logic         done;
  logic [W-1:0] hi;
  logic [W-1:0] lo;

  int n_cmp = 0;
  int n_bad = 0;
  logic [2*W-1:0] exp_q[$];
  string          name_q[$];

  mult_div_unit #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op),
    .rs_content(rs_content), .rt_content(rt_content),
    .mthi(mthi), .mtlo(mtlo),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h, required %h", nm, act, req);
    end
  endtask

  // Monitor: every done pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (rst_n && done) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_done: got hi=%h lo=%h, required no result", hi, lo);
      end else begin
        check({name_q.pop_front(), "_result"}, {hi, lo}, exp_q.pop_front());
      end
    end
  end

  task automatic wait_done(output int lat, output int bcnt);
    lat = 0;
    bcnt = 0;
    while (!done && lat < 100) begin
      if (busy) bcnt++;
      @(posedge clk); #1;
      lat++;
    end
    if (!done) begin
      n_cmp++;
      n_bad++;
      $display("FAIL done_timeout: got no done after %0d cycles, required done", lat);
    end
  endtask

  task automatic run_op(input string nm, input logic [1:0] o,
                        input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] eh, input logic [W-1:0] el,
                        input bit mv_lo);
    logic [W-1:0] lo_before;
    int lat, bcnt;
    lo_before = lo;
    exp_q.push_back({eh, el});
    name_q.push_back(nm);
    op = o; rs_content = a; rt_content = b; start = 1'b1; mtlo = mv_lo;
    @(posedge clk); #1;
    start = 1'b0; mtlo = 1'b0;
    if (mv_lo) check({nm, "_mtlo_dropped"}, lo, lo_before);
    wait_done(lat, bcnt);
    check({nm, "_latency"}, lat, 33);
    check({nm, "_busy_cycles"}, bcnt, 33);
  endtask

  initial begin
    int lat, bcnt;
    logic [W-1:0] hold_hi, hold_lo;

    repeat (2) @(posedge clk);
    #1;
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_hi", hi, 0);
    check("reset_lo", lo, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_op("multu_max", MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 0);
    run_op("mult_neg3x5", MULT, 32'hFFFFFFFD, 32'd5, 32'hFFFFFFFF, 32'hFFFFFFF1, 0);
    run_op("mult_minxmin", MULT, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 0);
    run_op("div_neg7by2", DIV, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 0);
    run_op("div_7byneg2", DIV, 32'd7, 32'hFFFFFFFE, 32'd1, 32'hFFFFFFFD, 0);
    run_op("divu_7by0", DIVU, 32'd7, 32'd0, 32'd7, 32'hFFFFFFFF, 0);
    run_op("div_neg8by0", DIV, 32'hFFFFFFF8, 32'd0, 32'hFFFFFFF8, 32'hFFFFFFFF, 0);
    run_op("div_overflow", DIV, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 0);

    // Start while busy, operand changes and mthi during RUN must all be ignored.
    exp_q.push_back({32'd2, 32'd14});
    name_q.push_back("divu_100by7");
    op = DIVU; rs_content = 32'd100; rt_content = 32'd7; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    op = MULTU; rs_content = 32'd2; rt_content = 32'd3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    hold_hi = hi;
    mthi = 1'b1;
    @(posedge clk); #1;
    mthi = 1'b0;
    check("mthi_while_busy", hi, hold_hi);
    @(posedge clk); #1;
    rs_content = 32'hDEADBEEF; rt_content = 32'd1;
    wait_done(lat, bcnt);
    check("busy_after_done", busy, 0);

    hold_lo = lo;
    rs_content = 32'h12345678; mthi = 1'b1;
    @(posedge clk); #1;
    mthi = 1'b0;
    check("mthi_hi", hi, 32'h12345678);
    check("mthi_lo_kept", lo, hold_lo);
    rs_content = 32'hCAFEF00D; mthi = 1'b1; mtlo = 1'b1;
    @(posedge clk); #1;
    mthi = 1'b0; mtlo = 1'b0;
    check("mthilo_both", {hi, lo}, {32'hCAFEF00D, 32'hCAFEF00D});

    run_op("multu_3x4_mtlo", MULTU, 32'd3, 32'd4, 32'd0, 32'd12, 1);

    // Reset in the middle of a multiply aborts it with nothing written.
    op = MULT; rs_content = 32'hFFFFFFFD; rt_content = 32'd5; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_hilo", {hi, lo}, 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("abort_hilo_held", {hi, lo}, 64'd0);
    run_op("multu_6x7", MULTU, 32'd6, 32'd7, 32'd0, 32'd42, 0);

    repeat (3) @(posedge clk);
    #1;
    check("scoreboard_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
